// File: rtl/layer3_pe_sched.sv
// Sequencer for the layer-3 PE array: walks output pixels, issues per-tap buffer/ROM reads,
// drives PE clear/valid and a per-pixel valid/ready output. Optional perf counters: LAYER3_SCHED_PERF_EN.
module layer3_pe_sched #(
  parameter int KERNEL_TAPS = 25,
  parameter int DIM_W       = 6,
  parameter int ADDR_W      = 16,
  parameter int WADDR_W     = 5,
  parameter int MEM_LAT     = 1,
  parameter int PE_LAT      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [DIM_W-1:0]   i_map_w,
  input  logic [DIM_W-1:0]   i_map_h,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_rd_en,
  output logic [ADDR_W-1:0]  o_data_addr,
  output logic [WADDR_W-1:0] o_weight_addr,
  output logic               o_pe_clear,
  output logic               o_pe_valid,
  output logic               o_out_valid,
  input  logic               i_out_ready,
`ifdef LAYER3_SCHED_PERF_EN
  output logic [31:0]        o_stall_cycles,
  output logic [31:0]        o_run_cycles,
`endif
  output logic [DIM_W-1:0]   o_pix_x,
  output logic [DIM_W-1:0]   o_pix_y
);

  localparam int DRN_W = $clog2(MEM_LAT + PE_LAT + 1);
  localparam logic [WADDR_W-1:0] TAP_LAST = WADDR_W'(KERNEL_TAPS - 1);
  localparam logic [DRN_W-1:0]   DRN_LAST = DRN_W'(MEM_LAT + PE_LAT - 1);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, FIN} state_t;

  state_t                    state_q, state_d;
  logic [WADDR_W-1:0]        tap_q, tap_d;
  logic [DRN_W-1:0]          drn_q, drn_d;
  logic [DIM_W-1:0]          w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]         idx_q, idx_d;
  logic                      busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]         daddr_q, daddr_d;
  logic [WADDR_W-1:0]        waddr_q, waddr_d;
  logic [MEM_LAT-1:0][1:0]   pipe_q, pipe_d;  // {rd_en, first_tap} delayed to PE timing
`ifdef LAYER3_SCHED_PERF_EN
  logic [31:0]               stall_q, stall_d, run_q, run_d;
`endif

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    drn_d   = drn_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (i_start) begin
        w_d     = i_map_w;
        h_d     = i_map_h;
        tap_d   = '0;
        x_d     = '0;
        y_d     = '0;
        idx_d   = '0;
        state_d = (i_map_w == '0 || i_map_h == '0) ? FIN : RUN;
      end
      RUN: if (tap_q == TAP_LAST) begin
        tap_d   = '0;
        drn_d   = '0;
        state_d = DRAIN;
      end else begin
        tap_d = tap_q + WADDR_W'(1);
      end
      DRAIN: if (drn_q == DRN_LAST) state_d = OUT;
             else drn_d = drn_q + DRN_W'(1);
      OUT: if (i_out_ready) begin
        if (x_q == w_q - DIM_W'(1) && y_q == h_q - DIM_W'(1)) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = RUN;
          if (x_q == w_q - DIM_W'(1)) begin
            x_d = '0;
            y_d = y_q + DIM_W'(1);
          end else begin
            x_d = x_q + DIM_W'(1);
          end
        end
      end
      // Zero-size maps enter FIN without the pulse; it is issued on the following cycle.
      FIN: if (done_q) state_d = IDLE;
           else done_d = 1'b1;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    rd_en_d     = (state_d == RUN);
    out_valid_d = (state_d == OUT);
    waddr_d     = rd_en_d ? tap_d : '0;
    daddr_d     = rd_en_d ? (idx_d * ADDR_W'(KERNEL_TAPS)) + ADDR_W'(tap_d) : '0;

    pipe_d = pipe_q << 2;
    pipe_d[0] = {rd_en_q, rd_en_q && (waddr_q == '0)};

`ifdef LAYER3_SCHED_PERF_EN
    stall_d = stall_q;
    run_d   = run_q;
    if (state_q == IDLE && i_start) begin
      stall_d = '0;
      run_d   = '0;
    end else begin
      if (busy_q && run_q != '1) run_d = run_q + 32'd1;
      if (state_q == OUT && !i_out_ready && stall_q != '1) stall_d = stall_q + 32'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      drn_q       <= '0;
      w_q         <= '0;
      h_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      daddr_q     <= '0;
      waddr_q     <= '0;
      pipe_q      <= '0;
`ifdef LAYER3_SCHED_PERF_EN
      stall_q     <= '0;
      run_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      drn_q       <= drn_d;
      w_q         <= w_d;
      h_q         <= h_d;
      x_q         <= x_d;
      y_q         <= y_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      out_valid_q <= out_valid_d;
      daddr_q     <= daddr_d;
      waddr_q     <= waddr_d;
      pipe_q      <= pipe_d;
`ifdef LAYER3_SCHED_PERF_EN
      stall_q     <= stall_d;
      run_q       <= run_d;
`endif
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_rd_en       = rd_en_q;
  assign o_data_addr   = daddr_q;
  assign o_weight_addr = waddr_q;
  assign o_pe_valid    = pipe_q[MEM_LAT-1][1];
  assign o_pe_clear    = pipe_q[MEM_LAT-1][0];
  assign o_out_valid   = out_valid_q;
  assign o_pix_x       = x_q;
  assign o_pix_y       = y_q;
`ifdef LAYER3_SCHED_PERF_EN
  assign o_stall_cycles = stall_q;
  assign o_run_cycles   = run_q;
`endif

endmodule

// File: tb/tb_layer3_pe_sched.sv
// Directed bench for layer3_pe_sched with default parameters (K=25, MEM_LAT=1, PE_LAT=2).
module tb_layer3_pe_sched;
  logic        clk = 1'b0;
  logic        rst, i_start, i_out_ready;
  logic [5:0]  i_map_w, i_map_h;
  logic        o_busy, o_done, o_rd_en, o_pe_clear, o_pe_valid, o_out_valid;
  logic [15:0] o_data_addr;
  logic [4:0]  o_weight_addr;
  logic [5:0]  o_pix_x, o_pix_y;
`ifdef LAYER3_SCHED_PERF_EN
  logic [31:0] o_stall_cycles, o_run_cycles;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  // {busy, done, rd_en, pe_clear, pe_valid, out_valid}
  wire [5:0] ctl = {o_busy, o_done, o_rd_en, o_pe_clear, o_pe_valid, o_out_valid};

  layer3_pe_sched dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_map_w(i_map_w), .i_map_h(i_map_h),
    .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en), .o_data_addr(o_data_addr),
    .o_weight_addr(o_weight_addr), .o_pe_clear(o_pe_clear), .o_pe_valid(o_pe_valid),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
`ifdef LAYER3_SCHED_PERF_EN
    .o_stall_cycles(o_stall_cycles), .o_run_cycles(o_run_cycles),
`endif
    .o_pix_x(o_pix_x), .o_pix_y(o_pix_y)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [5:0] w, input logic [5:0] h);
    i_map_w = w;
    i_map_h = h;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (ctl !== 6'b0 || o_data_addr !== 16'd0 || o_weight_addr !== 5'd0 || o_pix_x !== 6'd0 || o_pix_y !== 6'd0) begin
        n_fail++;
        $display("FAIL reset ctl=%b addr=%0d waddr=%0d x=%0d y=%0d, required all zero", ctl, o_data_addr, o_weight_addr, o_pix_x, o_pix_y);
      end
      step();
    end
  endtask

  task automatic test_single_pixel();
    logic [5:0] exp;
    i_out_ready = 1'b1;
    start_run(6'd1, 6'd1);
    for (int c = 1; c <= 32; c++) begin
      exp = {c <= 30, c == 30, c >= 1 && c <= 25, c == 2, c >= 2 && c <= 26, c == 29};
      n_checks++;
      if (ctl !== exp) begin
        n_fail++;
        $display("FAIL single ctl c=%0d got %b exp %b", c, ctl, exp);
      end
      if (c <= 25) begin
        n_checks++;
        if (o_data_addr !== 16'(c - 1) || o_weight_addr !== 5'(c - 1)) begin
          n_fail++;
          $display("FAIL single addr c=%0d got %0d/%0d exp %0d", c, o_data_addr, o_weight_addr, c - 1);
        end
      end
      step();
    end
  endtask

  task automatic test_multi_pixel();
    logic [5:0] exp;
    int tap, k, n_ov;
    n_ov = 0;
    i_out_ready = 1'b1;
    start_run(6'd3, 6'd2);
    for (int c = 1; c <= 180; c++) begin
      tap = (c - 1) % 29;
      k   = (c - 1) / 29;
      exp = {c <= 175, c == 175, c <= 174 && tap < 25,
             c >= 2 && c <= 174 && (c - 2) % 29 == 0,
             c >= 2 && c <= 174 && (c - 2) % 29 < 25,
             c <= 174 && tap == 28};
      n_checks++;
      if (ctl !== exp) begin
        n_fail++;
        $display("FAIL multi ctl c=%0d got %b exp %b", c, ctl, exp);
      end
      if (exp[2]) begin
        n_checks++;
        if (o_data_addr !== 16'(25 * k + tap) || o_weight_addr !== 5'(tap)) begin
          n_fail++;
          $display("FAIL multi addr c=%0d got %0d/%0d exp %0d/%0d", c, o_data_addr, o_weight_addr, 25 * k + tap, tap);
        end
      end
      if (exp[0]) begin
        n_checks++;
        if (o_pix_x !== 6'(k % 3) || o_pix_y !== 6'(k / 3)) begin
          n_fail++;
          $display("FAIL multi pix c=%0d got (%0d,%0d) exp (%0d,%0d)", c, o_pix_x, o_pix_y, k % 3, k / 3);
        end
      end
      if (o_out_valid === 1'b1) n_ov++;
      step();
    end
    n_checks++;
    if (n_ov !== 6) begin
      n_fail++;
      $display("FAIL multi pulse count got %0d exp 6", n_ov);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] exp;
    i_out_ready = 1'b0;
    start_run(6'd2, 6'd1);
    for (int c = 1; c <= 72; c++) begin
      i_out_ready = (c >= 39);
      exp = {c <= 69, c == 69, c <= 25 || (c >= 40 && c <= 64), c == 2 || c == 41,
             (c >= 2 && c <= 26) || (c >= 41 && c <= 65), (c >= 29 && c <= 39) || c == 68};
      n_checks++;
      if (ctl !== exp) begin
        n_fail++;
        $display("FAIL stall ctl c=%0d got %b exp %b", c, ctl, exp);
      end
      if (exp[0]) begin
        n_checks++;
        if (o_pix_x !== (c == 68 ? 6'd1 : 6'd0) || o_pix_y !== 6'd0) begin
          n_fail++;
          $display("FAIL stall pix c=%0d got (%0d,%0d)", c, o_pix_x, o_pix_y);
        end
      end
      if (exp[3]) begin
        n_checks++;
        if (o_data_addr !== 16'(c <= 25 ? c - 1 : c - 15)) begin
          n_fail++;
          $display("FAIL stall addr c=%0d got %0d", c, o_data_addr);
        end
      end
      step();
    end
    i_out_ready = 1'b1;
  endtask

  task automatic test_zero_dim();
    logic [5:0] exp;
    start_run(6'd0, 6'd5);
    for (int c = 1; c <= 4; c++) begin
      exp = {c <= 2, c == 2, 4'b0};
      n_checks++;
      if (ctl !== exp) begin
        n_fail++;
        $display("FAIL zero ctl c=%0d got %b exp %b", c, ctl, exp);
      end
      step();
    end
  endtask

  task automatic test_restart_abort();
    logic [5:0] exp;
    i_out_ready = 1'b1;
    start_run(6'd1, 6'd1);
    for (int c = 1; c <= 26; c++) begin
      if (c == 5) begin
        i_start = 1'b1;
        i_map_w = 6'd7;
      end
      if (c == 6) i_start = 1'b0;
      if (c == 26) rst = 1'b1;
      exp = {1'b1, 1'b0, c <= 25, c == 2, c >= 2, 1'b0};
      n_checks++;
      if (ctl !== exp || (c <= 25 && o_data_addr !== 16'(c - 1))) begin
        n_fail++;
        $display("FAIL abort run c=%0d ctl %b exp %b addr %0d", c, ctl, exp, o_data_addr);
      end
      step();
    end
    rst = 1'b0;
    for (int c = 27; c <= 34; c++) begin
      n_checks++;
      if (ctl !== 6'b0 || o_data_addr !== 16'd0 || o_pix_x !== 6'd0) begin
        n_fail++;
        $display("FAIL abort idle c=%0d ctl %b addr %0d, required zero", c, ctl, o_data_addr);
      end
      step();
    end
    test_single_pixel();
  endtask

`ifdef LAYER3_SCHED_PERF_EN
  task automatic test_perf();
    i_out_ready = 1'b0;
    start_run(6'd1, 6'd1);
    for (int c = 1; c <= 34; c++) begin
      i_out_ready = (c >= 33);
      step();
    end
    n_checks++;
    if (o_stall_cycles !== 32'd4 || o_run_cycles !== 32'd34) begin
      n_fail++;
      $display("FAIL perf stall=%0d run=%0d exp 4/34", o_stall_cycles, o_run_cycles);
    end
    i_out_ready = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_out_ready = 1'b0;
    i_map_w = '0;
    i_map_h = '0;
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_single_pixel();
    test_multi_pixel();
    test_backpressure();
    test_zero_dim();
    test_restart_abort();
`ifdef LAYER3_SCHED_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
